// File: rtl/arm_mem_pkg.sv
// Shared types and sizes for the data-memory bridge.
// Holds the bridge state encoding, bus widths and the default timeout.
package arm_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TIMEOUT_CYCLES_DFLT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_bridge.sv
// Bridges single-cycle datapath loads/stores onto a valid/ready bus.
// Optional REQ-state timeout is enabled by defining DMEM_BRIDGE_TIMEOUT_EN.
module dmem_bridge
    import arm_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              Stall,
    output logic              MemErr,
    output logic              bus_valid,
    output logic              bus_write,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_err
);

    state_e            state_q, state_d;
    logic              bus_write_q, bus_write_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              served_q, served_d;
    logic              req, misal, take, bad, expired;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive REQ cycles; cleared whenever REQ is left.
    always_comb begin
        expired = (state_q == REQ) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        cnt_d = '0;
        if (state_q == REQ && !bus_ready && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    wire [31:0] unused_timeout = TIMEOUT_CYCLES;
    assign expired = 1'b0;
`endif

    // Request decode and next-state / capture logic.
    always_comb begin
        req   = MemWrite | MemRead;
        misal = |Addr[1:0];
        take  = (state_q == IDLE) && req && !served_q && !misal;
        bad   = (state_q == IDLE) && req && !served_q && misal;

        state_d     = state_q;
        bus_write_d = bus_write_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        served_d    = served_q;

        unique case (state_q)
            IDLE: begin
                if (take) begin
                    state_d     = REQ;
                    bus_write_d = MemWrite;
                    bus_addr_d  = {Addr[ADDR_W-1:2], 2'b00};
                    bus_wdata_d = WriteData;
                end else if (!req) begin
                    served_d = 1'b0;
                end
            end
            REQ: begin
                if (bus_ready) begin
                    state_d = DONE;
                    err_d   = bus_err;
                    if (!bus_write_q) begin
                        rdata_d = bus_rdata;
                    end
                end else if (expired) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            DONE: begin
                state_d  = IDLE;
                served_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-transaction registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bus_write_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            served_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_write_q <= bus_write_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            served_q    <= served_d;
        end
    end

    assign bus_valid = (state_q == REQ);
    assign bus_write = bus_write_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign Stall     = take || (state_q == REQ);
    assign MemErr    = bad || ((state_q == DONE) && err_q);
    assign ReadData  = bad ? '0 : rdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed self-checking bench for dmem_bridge.
// Define DMEM_BRIDGE_TIMEOUT_EN to also exercise the REQ timeout.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite, MemRead;
    logic [31:0] Addr, WriteData;
    logic [31:0] ReadData;
    logic        Stall, MemErr;
    logic        bus_valid, bus_write;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int vectors = 0;
    int errors = 0;
    int stalls = 0;

    always #5 clk = ~clk;

    dmem_bridge #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .MemWrite(MemWrite),
        .MemRead(MemRead),
        .Addr(Addr),
        .WriteData(WriteData),
        .ReadData(ReadData),
        .Stall(Stall),
        .MemErr(MemErr),
        .bus_valid(bus_valid),
        .bus_write(bus_write),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ready(bus_ready),
        .bus_rdata(bus_rdata),
        .bus_err(bus_err)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        MemWrite = 1'b0;
        MemRead = 1'b0;
        Addr = '0;
        WriteData = '0;
        bus_ready = 1'b0;
        bus_rdata = '0;
        bus_err = 1'b0;

        @(negedge clk);
        check("rst_stall", Stall, 0);
        check("rst_valid", bus_valid, 0);
        check("rst_rdata", ReadData, 0);
        check("rst_memerr", MemErr, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_write", bus_write, 0);
        next_cycle();
        reset = 1'b0;

        // Load 0x100, two wait cycles then ready.
        MemRead = 1'b1;
        Addr = 32'h100;
        @(negedge clk);
        check("ld_idle_stall", Stall, 1);
        check("ld_idle_valid", bus_valid, 0);
        stalls += int'(Stall);
        next_cycle();
        @(negedge clk);
        check("ld_req_valid", bus_valid, 1);
        check("ld_req_addr", bus_addr, 32'h100);
        check("ld_req_write", bus_write, 0);
        stalls += int'(Stall);
        next_cycle();
        @(negedge clk);
        check("ld_wait_valid", bus_valid, 1);
        stalls += int'(Stall);
        next_cycle();
        bus_ready = 1'b1;
        bus_rdata = 32'hDEADBEEF;
        @(negedge clk);
        stalls += int'(Stall);
        next_cycle();
        bus_ready = 1'b0;
        bus_rdata = '0;
        @(negedge clk);
        check("ld_done_stall", Stall, 0);
        check("ld_done_rdata", ReadData, 32'hDEADBEEF);
        check("ld_done_memerr", MemErr, 0);
        check("ld_done_valid", bus_valid, 0);
        check("ld_stall_cycles", stalls, 4);
        next_cycle();
        @(negedge clk);
        check("ld_served_stall", Stall, 0);
        check("ld_served_valid", bus_valid, 0);
        next_cycle();
        MemRead = 1'b0;
        @(negedge clk);
        check("idle_stall", Stall, 0);
        check("idle_valid", bus_valid, 0);

        // Store 0x204 with immediate ready.
        next_cycle();
        MemWrite = 1'b1;
        Addr = 32'h204;
        WriteData = 32'h12345678;
        @(negedge clk);
        check("st_idle_stall", Stall, 1);
        next_cycle();
        bus_ready = 1'b1;
        @(negedge clk);
        check("st_valid", bus_valid, 1);
        check("st_write", bus_write, 1);
        check("st_addr", bus_addr, 32'h204);
        check("st_wdata", bus_wdata, 32'h12345678);
        next_cycle();
        bus_ready = 1'b0;
        @(negedge clk);
        check("st_done_rdata", ReadData, 32'hDEADBEEF);
        check("st_done_stall", Stall, 0);
        check("st_done_memerr", MemErr, 0);
        next_cycle();
        MemWrite = 1'b0;
        @(negedge clk);
        check("st_after_valid", bus_valid, 0);

        // Misaligned load at 0x103.
        next_cycle();
        MemRead = 1'b1;
        Addr = 32'h103;
        @(negedge clk);
        check("mis_memerr", MemErr, 1);
        check("mis_stall", Stall, 0);
        check("mis_rdata", ReadData, 0);
        check("mis_valid", bus_valid, 0);
        next_cycle();
        MemRead = 1'b0;
        @(negedge clk);
        check("mis_pulse_end", MemErr, 0);
        check("mis_no_bus", bus_valid, 0);

        // Load that completes with a bus error.
        next_cycle();
        MemRead = 1'b1;
        Addr = 32'h300;
        @(negedge clk);
        check("be_idle_stall", Stall, 1);
        next_cycle();
        bus_ready = 1'b1;
        bus_err = 1'b1;
        bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        check("be_req_valid", bus_valid, 1);
        check("be_req_memerr", MemErr, 0);
        next_cycle();
        bus_ready = 1'b0;
        bus_err = 1'b0;
        bus_rdata = '0;
        @(negedge clk);
        check("be_done_memerr", MemErr, 1);
        check("be_done_rdata", ReadData, 32'hCAFEF00D);
        next_cycle();
        MemRead = 1'b0;
        @(negedge clk);
        check("be_pulse_end", MemErr, 0);

        // Read and write together: write wins.
        next_cycle();
        MemWrite = 1'b1;
        MemRead = 1'b1;
        Addr = 32'h40;
        WriteData = 32'hA5A5A5A5;
        @(negedge clk);
        check("both_stall", Stall, 1);
        next_cycle();
        bus_ready = 1'b1;
        @(negedge clk);
        check("both_valid", bus_valid, 1);
        check("both_write", bus_write, 1);
        check("both_addr", bus_addr, 32'h40);
        next_cycle();
        bus_ready = 1'b0;
        @(negedge clk);
        check("both_done_rdata", ReadData, 32'hCAFEF00D);
        next_cycle();
        @(negedge clk);
        check("both_single_valid", bus_valid, 0);
        check("both_single_stall", Stall, 0);
        next_cycle();
        MemWrite = 1'b0;
        MemRead = 1'b0;

        // Reset in the second REQ cycle abandons the load.
        next_cycle();
        MemRead = 1'b1;
        Addr = 32'h500;
        @(negedge clk);
        check("rr_idle_stall", Stall, 1);
        next_cycle();
        @(negedge clk);
        check("rr_req1_valid", bus_valid, 1);
        next_cycle();
        @(negedge clk);
        check("rr_req2_valid", bus_valid, 1);
        reset = 1'b1;
        MemRead = 1'b0;
        #1;
        check("rr_async_valid", bus_valid, 0);
        check("rr_async_stall", Stall, 0);
        next_cycle();
        reset = 1'b0;
        bus_ready = 1'b1;
        @(negedge clk);
        check("rr_rel_valid", bus_valid, 0);
        check("rr_rel_memerr", MemErr, 0);
        next_cycle();
        bus_ready = 1'b0;
        @(negedge clk);
        check("rr_rel2_memerr", MemErr, 0);
        check("rr_rel2_rdata", ReadData, 0);

`ifdef DMEM_BRIDGE_TIMEOUT_EN
        // No ready: bus_valid drops after four REQ cycles.
        next_cycle();
        MemRead = 1'b1;
        Addr = 32'h600;
        @(negedge clk);
        check("to_idle_stall", Stall, 1);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            @(negedge clk);
            check("to_req_valid", bus_valid, 1);
        end
        next_cycle();
        @(negedge clk);
        check("to_done_valid", bus_valid, 0);
        check("to_done_memerr", MemErr, 1);
        check("to_done_rdata", ReadData, 0);
        next_cycle();
        MemRead = 1'b0;
`endif

        next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
